// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types for the pipeline stall controller and the hazard unit that feeds it.
package pipe_ctrl_pkg;

  localparam int unsigned STALL_W_DEF = 2;

  typedef logic [STALL_W_DEF-1:0] stall_req_t;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard-unit request / pipeline-enable bundle; master drives requests, slave is the controller.
interface pipeline_stall_controller_if
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned STALL_W = STALL_W_DEF
);
  logic [STALL_W-1:0] hz_stall;
  logic               hz_flush;
  logic               mem_busy;
  logic               PC_Write;
  logic               IFID_Write;
  logic               IFID_Flush;
  logic               IDEX_Bubble;
  logic               Pipe_Freeze;
  logic               stall_active;
  logic [CNT_W-1:0]   stall_cycles;
  logic [CNT_W-1:0]   flush_count;
  logic [CNT_W-1:0]   freeze_cycles;

  modport master (
    output hz_stall, hz_flush, mem_busy,
    input  PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Freeze,
    input  stall_active, stall_cycles, flush_count, freeze_cycles
  );

  modport slave (
    input  hz_stall, hz_flush, mem_busy,
    output PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Freeze,
    output stall_active, stall_cycles, flush_count, freeze_cycles
  );
endinterface

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/pipeline_stall_controller.sv
// Turns one-cycle hazard requests into held stall / flush / freeze enables for the 5-stage pipe.
module pipeline_stall_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned STALL_W = STALL_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  pipeline_stall_controller_if.slave  bus
);
  state_t             state, state_n;
  logic [STALL_W-1:0] rem, rem_n;
  logic               inc_stall, inc_flush, inc_freeze;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      rem   <= '0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
    end
  end

  always_comb begin
    state_n          = state;
    rem_n            = rem;
    inc_stall        = 1'b0;
    inc_flush        = 1'b0;
    inc_freeze       = 1'b0;
    bus.PC_Write     = 1'b1;
    bus.IFID_Write   = 1'b1;
    bus.IFID_Flush   = 1'b0;
    bus.IDEX_Bubble  = 1'b0;
    bus.Pipe_Freeze  = 1'b0;
    bus.stall_active = 1'b0;

    if (rst) begin
      bus.PC_Write    = 1'b0;
      bus.IFID_Write  = 1'b0;
      bus.IDEX_Bubble = 1'b1;
    end else if (bus.mem_busy) begin
      // Whole pipe holds; the remaining stall count is preserved untouched.
      bus.Pipe_Freeze = 1'b1;
      bus.PC_Write    = 1'b0;
      bus.IFID_Write  = 1'b0;
      inc_freeze      = 1'b1;
    end else if (state == STALL) begin
      bus.PC_Write     = 1'b0;
      bus.IFID_Write   = 1'b0;
      bus.IDEX_Bubble  = 1'b1;
      bus.stall_active = 1'b1;
      inc_stall        = 1'b1;
      rem_n            = rem - 1'b1;
      if (rem == STALL_W'(1)) begin
        state_n = RUN;
      end
    end else if (bus.hz_stall != '0) begin
      // Stall starts this cycle; a coincident flush is dropped as its branch result is stale.
      bus.PC_Write     = 1'b0;
      bus.IFID_Write   = 1'b0;
      bus.IDEX_Bubble  = 1'b1;
      bus.stall_active = 1'b1;
      inc_stall        = 1'b1;
      if (bus.hz_stall > STALL_W'(1)) begin
        state_n = STALL;
        rem_n   = bus.hz_stall - 1'b1;
      end
    end else if (bus.hz_flush) begin
      bus.IFID_Flush = 1'b1;
      inc_flush      = 1'b1;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_stall),
    .count (bus.stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_flush),
    .count (bus.flush_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_freeze_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_freeze),
    .count (bus.freeze_cycles)
  );
endmodule
